// File: rtl/im_boot_loader_if.sv
// Byte-stream in / instruction-memory write port out for the boot loader.
// The loader is the slave side; the UART/IM environment is the master side.
interface im_boot_loader_if #(
    parameter int ADDR_W = 11
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              restart;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;
    logic              cpu_hold;
    logic              done;
    logic              err;

    modport master (
        output rx_data, rx_valid, restart,
        input  im_we, im_addr, im_wdata, cpu_hold, done, err
    );

    modport slave (
        input  rx_data, rx_valid, restart,
        output im_we, im_addr, im_wdata, cpu_hold, done, err
    );
endinterface

// File: rtl/im_boot_loader.sv
// Packs a big-endian counted byte stream into 32-bit IM words and holds the CPU until loaded.
// Optional trailing XOR checksum byte is enabled with `define LOADER_CKSUM_EN.
module im_boot_loader #(
    parameter int ADDR_W   = 11,
    parameter bit HOLD_RST = 1'b1
) (
    input logic             clk,
    input logic             reset,
    im_boot_loader_if.slave bus
);
    localparam logic [31:0] DEPTH = 32'(1) << ADDR_W;

    typedef enum logic [2:0] {
        S_CNT_HI,
        S_CNT_LO,
        S_DATA,
`ifdef LOADER_CKSUM_EN
        S_CKSUM,
`endif
        S_DONE
    } state_t;

    state_t            r_state;
    logic [15:0]       r_cnt;
    logic [15:0]       r_wordIdx;
    logic [1:0]        r_byteIdx;
    logic [23:0]       r_shift;
    logic              r_im_we;
    logic [ADDR_W-1:0] r_im_addr;
    logic [31:0]       r_im_wdata;
    logic              r_cpu_hold;
    logic              r_done;
    logic              r_err;
`ifdef LOADER_CKSUM_EN
    logic [7:0]        r_cksum;
    logic              w_ckBad;
`endif

    logic [15:0] w_nextCnt;
    logic        w_lastWord;
    logic        w_overflow;
    logic        w_wordDone;

    assign w_nextCnt  = {r_cnt[15:8], bus.rx_data};
    assign w_lastWord = (r_wordIdx == r_cnt - 16'd1);
    assign w_overflow = ({16'd0, r_wordIdx} >= DEPTH);
    assign w_wordDone = (r_byteIdx == 2'd3);
`ifdef LOADER_CKSUM_EN
    assign w_ckBad    = (bus.rx_data != r_cksum);
`endif

    // im_addr tracks the word index: it steps after each write and saturates instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_CNT_HI;
            r_cnt      <= 16'd0;
            r_wordIdx  <= 16'd0;
            r_byteIdx  <= 2'd0;
            r_shift    <= 24'd0;
            r_im_we    <= 1'b0;
            r_im_addr  <= '0;
            r_im_wdata <= 32'd0;
            r_cpu_hold <= HOLD_RST;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
`ifdef LOADER_CKSUM_EN
            r_cksum    <= 8'd0;
`endif
        end else begin
            r_im_we <= 1'b0;
            if (r_im_we && (r_im_addr != {ADDR_W{1'b1}})) begin
                r_im_addr <= r_im_addr + 1'b1;
            end
            if (bus.restart) begin
                r_state    <= S_CNT_HI;
                r_cnt      <= 16'd0;
                r_wordIdx  <= 16'd0;
                r_byteIdx  <= 2'd0;
                r_im_addr  <= '0;
                r_cpu_hold <= 1'b1;
                r_done     <= 1'b0;
                r_err      <= 1'b0;
`ifdef LOADER_CKSUM_EN
                r_cksum    <= 8'd0;
`endif
            end else begin
                case (r_state)
                    S_CNT_HI: begin
                        if (bus.rx_valid) begin
                            r_cnt[15:8] <= bus.rx_data;
                            r_state     <= S_CNT_LO;
                        end
                    end
                    S_CNT_LO: begin
                        if (bus.rx_valid) begin
                            r_cnt[7:0] <= bus.rx_data;
                            if (w_nextCnt == 16'd0) begin
`ifdef LOADER_CKSUM_EN
                                r_state <= S_CKSUM;
`else
                                r_state    <= S_DONE;
                                r_done     <= 1'b1;
                                r_cpu_hold <= r_err;
`endif
                            end else begin
                                r_state <= S_DATA;
                            end
                        end
                    end
                    // Overflowing words are still consumed so the frame stays in step.
                    S_DATA: begin
                        if (bus.rx_valid) begin
                            r_byteIdx <= r_byteIdx + 2'd1;
                            r_shift   <= {r_shift[15:0], bus.rx_data};
`ifdef LOADER_CKSUM_EN
                            r_cksum   <= r_cksum ^ bus.rx_data;
`endif
                            if (w_wordDone) begin
                                r_wordIdx <= r_wordIdx + 16'd1;
                                if (w_overflow) begin
                                    r_err <= 1'b1;
                                end else begin
                                    r_im_we    <= 1'b1;
                                    r_im_wdata <= {r_shift, bus.rx_data};
                                end
                                if (w_lastWord) begin
`ifdef LOADER_CKSUM_EN
                                    r_state <= S_CKSUM;
`else
                                    r_state <= S_DONE;
`endif
                                end
                            end
                        end
                    end
`ifdef LOADER_CKSUM_EN
                    S_CKSUM: begin
                        if (bus.rx_valid) begin
                            r_err      <= r_err | w_ckBad;
                            r_cpu_hold <= r_err | w_ckBad;
                            r_done     <= 1'b1;
                            r_state    <= S_DONE;
                        end
                    end
`endif
                    S_DONE: begin
                        r_done     <= 1'b1;
                        r_cpu_hold <= r_err;
                    end
                    default: begin
                        r_state <= S_CNT_HI;
                    end
                endcase
            end
        end
    end

    assign bus.im_we    = r_im_we;
    assign bus.im_addr  = r_im_addr;
    assign bus.im_wdata = r_im_wdata;
    assign bus.cpu_hold = r_cpu_hold;
    assign bus.done     = r_done;
    assign bus.err      = r_err;
endmodule

// File: tb/tb_im_boot_loader.sv
// Randomized frame bench for im_boot_loader with a small IM (8 words) so overflow is reachable.
module tb_im_boot_loader;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 1 << ADDR_W;
`ifdef LOADER_CKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic clk;
    logic reset;
    int   checkCount;
    int   passCount;

    im_boot_loader_if #(.ADDR_W(ADDR_W)) bus ();

    im_boot_loader #(
        .ADDR_W  (ADDR_W),
        .HOLD_RST(1'b1)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drives one byte strobe, then checks the write pulse that must (or must not) follow it.
    task automatic applyStimulus(input logic [7:0] b, input bit expWe, input int expAddr,
                                 input logic [31:0] expData, input int gap);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        checkOutput("weStrobe", 32'(bus.im_we), 32'(expWe));
        if (expWe) begin
            checkOutput("weAddr", 32'(bus.im_addr), 32'(expAddr));
            checkOutput("weData", bus.im_wdata, expData);
        end
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            checkOutput("weIdle", 32'(bus.im_we), 32'd0);
        end
    endtask

    task automatic checkLoadState();
        checkOutput("ldWe", 32'(bus.im_we), 32'd0);
        checkOutput("ldAddr", 32'(bus.im_addr), 32'd0);
        checkOutput("ldHold", 32'(bus.cpu_hold), 32'd1);
        checkOutput("ldDone", 32'(bus.done), 32'd0);
        checkOutput("ldErr", 32'(bus.err), 32'd0);
    endtask

    task automatic pulseRestart(input bit withByte);
        bus.restart  = 1'b1;
        bus.rx_valid = withByte;
        bus.rx_data  = 8'($urandom_range(1, 255));
        @(negedge clk);
        bus.restart  = 1'b0;
        bus.rx_valid = 1'b0;
        checkLoadState();
    endtask

    // Reference: word k of the frame lands at address k when k < DEPTH; err if any word overflows
    // or the checksum is wrong; done with cpu_hold released only when err is clear.
    task automatic sendFrame(input int n, input bit useFixed, input logic [31:0] fixedWord,
                             input bit badCk);
        logic [15:0] nn;
        logic [31:0] word;
        logic [7:0]  b;
        logic [7:0]  ck;
        bit          expErr;
        bit          fin;
        int          written;
        nn     = 16'(n);
        ck     = 8'd0;
        expErr = (n > DEPTH);
        fin    = (n == 0) && !CK;
        applyStimulus(nn[15:8], 1'b0, 0, 32'd0, $urandom_range(0, 2));
        applyStimulus(nn[7:0], 1'b0, 0, 32'd0, fin ? 0 : $urandom_range(0, 2));
        for (int k = 0; k < n; k++) begin
            word = useFixed ? fixedWord : $urandom;
            for (int j = 0; j < 4; j++) begin
                b   = word[31-8*j -: 8];
                ck  = ck ^ b;
                fin = (k == n - 1) && (j == 3) && !CK;
                applyStimulus(b, (j == 3) && (k < DEPTH), k, word, fin ? 0 : $urandom_range(0, 2));
            end
        end
        if (CK) begin
            b      = badCk ? (ck ^ 8'($urandom_range(1, 255))) : ck;
            expErr = expErr | badCk;
            applyStimulus(b, 1'b0, 0, 32'd0, 0);
        end
        if (!CK && n > 0) begin
            checkOutput("doneEarly", 32'(bus.done), 32'd0);
            @(negedge clk);
        end
        checkOutput("done", 32'(bus.done), 32'd1);
        checkOutput("err", 32'(bus.err), 32'(expErr));
        checkOutput("cpuHold", 32'(bus.cpu_hold), 32'(expErr));
        written = (n < DEPTH) ? n : DEPTH;
        if (written < DEPTH) begin
            checkOutput("endAddr", 32'(bus.im_addr), 32'(written));
        end
    endtask

    initial begin
        checkCount   = 0;
        passCount    = 0;
        reset        = 1'b1;
        bus.rx_data  = 8'd0;
        bus.rx_valid = 1'b0;
        bus.restart  = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        checkLoadState();
        checkOutput("rstWdata", bus.im_wdata, 32'd0);

        sendFrame(1, 1'b1, 32'hDEADBEEF, 1'b0);
        pulseRestart(1'b0);
        sendFrame(3, 1'b0, 32'd0, 1'b0);
        pulseRestart(1'b0);
        sendFrame(0, 1'b0, 32'd0, 1'b0);
        pulseRestart(1'b0);
        sendFrame(10, 1'b0, 32'd0, 1'b0);
        pulseRestart(1'b0);
        sendFrame(1, 1'b1, 32'h01020408, 1'b1);
        pulseRestart(1'b0);

        for (int f = 0; f < 10; f++) begin
            sendFrame($urandom_range(0, 12), 1'b0, 32'd0, 1'($urandom_range(0, 1)));
            for (int i = 0; i < 3; i++) begin
                applyStimulus(8'($urandom), 1'b0, 0, 32'd0, 0);
            end
            checkOutput("doneHold", 32'(bus.done), 32'd1);
            pulseRestart(1'($urandom_range(0, 1)));
        end

        // Restart mid word 1 with a coincident byte, which must be dropped.
        applyStimulus(8'h00, 1'b0, 0, 32'd0, 0);
        applyStimulus(8'h04, 1'b0, 0, 32'd0, 1);
        applyStimulus(8'hA1, 1'b0, 0, 32'd0, 0);
        applyStimulus(8'hA2, 1'b0, 0, 32'd0, 0);
        applyStimulus(8'hA3, 1'b0, 0, 32'd0, 0);
        applyStimulus(8'hA4, 1'b1, 0, 32'hA1A2A3A4, 1);
        applyStimulus(8'hB1, 1'b0, 0, 32'd0, 0);
        applyStimulus(8'hB2, 1'b0, 0, 32'd0, 0);
        pulseRestart(1'b1);
        sendFrame(1, 1'b1, 32'h11223344, 1'b0);
        pulseRestart(1'b0);

        // Synchronous reset mid-load discards the partial word.
        applyStimulus(8'h00, 1'b0, 0, 32'd0, 0);
        applyStimulus(8'h02, 1'b0, 0, 32'd0, 0);
        applyStimulus(8'hC1, 1'b0, 0, 32'd0, 0);
        applyStimulus(8'hC2, 1'b0, 0, 32'd0, 0);
        applyStimulus(8'hC3, 1'b0, 0, 32'd0, 0);
        applyStimulus(8'hC4, 1'b1, 0, 32'hC1C2C3C4, 0);
        applyStimulus(8'hD1, 1'b0, 0, 32'd0, 0);
        reset        = 1'b1;
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'hD2;
        @(negedge clk);
        reset        = 1'b0;
        bus.rx_valid = 1'b0;
        checkLoadState();
        checkOutput("rstWdata2", bus.im_wdata, 32'd0);
        sendFrame(2, 1'b0, 32'd0, 1'b0);
        pulseRestart(1'b0);

        // Count high byte in use: 256 words, only the first DEPTH are written.
        sendFrame(256, 1'b0, 32'd0, 1'b0);

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
